// File: rtl/fp_add_normaliser_pipe_if.sv
// Stream interface for the floating-point post-addition normaliser.
// The master side produces raw adder beats and consumes normalised results.
// The slave side is the normaliser pipeline itself.
interface fp_add_normaliser_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 25
);
  logic             in_valid;
  logic             in_ready;
  logic [EXP_W-1:0] in_e;
  logic [MAN_W-1:0] in_m;
  logic             out_valid;
  logic             out_ready;
  logic [EXP_W-1:0] out_e;
  logic [MAN_W-1:0] out_m;
  logic             out_zero;
  logic             out_ovf;
  logic             out_unf;

  modport master (
    output in_valid, in_e, in_m, out_ready,
    input  in_ready, out_valid, out_e, out_m, out_zero, out_ovf, out_unf
  );

  modport slave (
    input  in_valid, in_e, in_m, out_ready,
    output in_ready, out_valid, out_e, out_m, out_zero, out_ovf, out_unf
  );
endinterface

// File: rtl/fp_add_normaliser_pipe.sv
// Two-stage post-addition normaliser with valid/ready handshake.
// Stage 1 classifies the raw adder result (carry, zero, leading-zero count).
// Stage 2 shifts mantissa and adjusts exponent, flagging zero/overflow/underflow.
// Optional feature: define FP_NORM_DENORM_EN to produce gradual denormals on
// underflow; otherwise underflowing results are flushed to zero.
module fp_add_normaliser_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 25
) (
  input logic                     clk,
  input logic                     rst_n,
  fp_add_normaliser_pipe_if.slave bus
);

  localparam int LZC_W = $clog2(MAN_W);
  localparam int XE_W  = EXP_W + 1;
  localparam logic [XE_W-1:0] E_MAX = {1'b0, {EXP_W{1'b1}}};

  logic             s1_en;
  logic             s2_en;

  logic             s1_valid;
  logic [EXP_W-1:0] s1_e;
  logic [MAN_W-1:0] s1_m;
  logic             s1_carry;
  logic             s1_zero;
  logic [LZC_W-1:0] s1_lzc;

  logic [LZC_W-1:0] lzc_next;

  logic             s2_valid;
  logic [EXP_W-1:0] s2_e;
  logic [MAN_W-1:0] s2_m;
  logic             s2_zero;
  logic             s2_ovf;
  logic             s2_unf;

  logic [EXP_W-1:0] nx_e;
  logic [MAN_W-1:0] nx_m;
  logic             nx_zero;
  logic             nx_ovf;
  logic             nx_unf;
  logic [XE_W-1:0]  e_ext;
  logic [XE_W-1:0]  e_inc;
`ifdef FP_NORM_DENORM_EN
  logic [EXP_W-1:0] den_sh;
`endif

  // A stage may load when its own slot is free or is being drained downstream.
  assign s2_en         = !s2_valid || bus.out_ready;
  assign s1_en         = !s1_valid || s2_en;
  assign bus.in_ready  = s1_en;
  assign bus.out_valid = s2_valid;
  assign bus.out_e     = s2_e;
  assign bus.out_m     = s2_m;
  assign bus.out_zero  = s2_zero;
  assign bus.out_ovf   = s2_ovf;
  assign bus.out_unf   = s2_unf;

  // Leading-zero count below the carry bit; highest set bit wins, all-zero gives MAN_W-1.
  always_comb begin
    lzc_next = LZC_W'(MAN_W - 1);
    for (int i = 0; i <= MAN_W - 2; i++) begin
      if (bus.in_m[i]) begin
        lzc_next = LZC_W'(MAN_W - 2 - i);
      end
    end
  end

  // Stage 1 register: capture the raw beat together with its classification.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_e     <= '0;
      s1_m     <= '0;
      s1_carry <= 1'b0;
      s1_zero  <= 1'b0;
      s1_lzc   <= '0;
    end else if (s1_en) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_e     <= bus.in_e;
        s1_m     <= bus.in_m;
        s1_carry <= bus.in_m[MAN_W-1];
        s1_zero  <= (bus.in_m == '0);
        s1_lzc   <= lzc_next;
      end
    end
  end

  // Stage 2 adjust: priority zero, carry, already normal, left shift, underflow.
  always_comb begin
    e_ext   = {1'b0, s1_e};
    e_inc   = e_ext + XE_W'(1);
    nx_e    = s1_e;
    nx_m    = s1_m;
    nx_zero = 1'b0;
    nx_ovf  = 1'b0;
    nx_unf  = 1'b0;
`ifdef FP_NORM_DENORM_EN
    den_sh  = (s1_e == '0) ? '0 : s1_e - EXP_W'(1);
`endif
    if (s1_zero) begin
      nx_e    = '0;
      nx_m    = '0;
      nx_zero = 1'b1;
    end else if (s1_carry) begin
      // An exponent already at infinity is treated as overflow too, so nothing wraps.
      if (e_inc >= E_MAX) begin
        nx_e   = '1;
        nx_m   = '0;
        nx_ovf = 1'b1;
      end else begin
        nx_e = e_inc[EXP_W-1:0];
        nx_m = (s1_m >> 1) | MAN_W'(s1_m[0]);
      end
    end else if (s1_m[MAN_W-2]) begin
      nx_e = s1_e;
      nx_m = s1_m;
    end else if (XE_W'(s1_lzc) < e_ext) begin
      nx_m = s1_m << s1_lzc;
      nx_e = s1_e - EXP_W'(s1_lzc);
    end else begin
      nx_unf = 1'b1;
`ifdef FP_NORM_DENORM_EN
      nx_e    = '0;
      nx_m    = s1_m << den_sh;
      nx_zero = (nx_m == '0);
`else
      nx_e    = '0;
      nx_m    = '0;
      nx_zero = 1'b1;
`endif
    end
  end

  // Stage 2 register: holds the presented result steady while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_e     <= '0;
      s2_m     <= '0;
      s2_zero  <= 1'b0;
      s2_ovf   <= 1'b0;
      s2_unf   <= 1'b0;
    end else if (s2_en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_e    <= nx_e;
        s2_m    <= nx_m;
        s2_zero <= nx_zero;
        s2_ovf  <= nx_ovf;
        s2_unf  <= nx_unf;
      end
    end
  end

endmodule

// File: doc/fp_add_normaliser_pipe.md
# fp_add_normaliser_pipe

Pipelined, parametrised post-addition normaliser for the floating-point adder datapath. It sits between the mantissa adder/subtractor and the rounder. It accepts a raw exponent and an unnormalised mantissa that carries one carry bit and a hidden bit, and produces a normalised exponent/mantissa pair with carry, zero, overflow and underflow handling. Data moves through two register stages with a valid/ready handshake and full backpressure.

## Interface
Parameters:
- EXP_W, 8, exponent width.
- MAN_W, 25, input mantissa width.
  - Bit MAN_W-1 is the carry bit.
  - Bit MAN_W-2 is the hidden bit.
  - Bits below the hidden bit are fraction plus guard bits.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_e  in  EXP_W  biased exponent from the adder.
- in_m  in  MAN_W  unnormalised mantissa from the adder.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the output beat.
- out_e  out  EXP_W  normalised exponent.
- out_m  out  MAN_W  normalised mantissa; bit MAN_W-1 is always 0 on output.
- out_zero  out  1  result is exact zero.
- out_ovf  out  1  exponent overflow; result is infinity.
- out_unf  out  1  exponent underflow.

## Operation
Stage 1 (classify) registers in_e and in_m plus:
- carry = in_m[MAN_W-1].
- zero = (in_m == 0).
- lzc = count of zeros from bit MAN_W-2 down to the first 1. Width is clog2(MAN_W).

Stage 2 (adjust) computes the output, checking these cases in priority order:
1. zero: out_e = 0, out_m = 0, out_zero = 1.
2. carry:
   - Shift out_m right by 1. OR the bit shifted out into out_m[0] (sticky).
   - out_e = in_e + 1.
   - If in_e + 1 equals all-ones: out_e = all-ones, out_m = 0, out_ovf = 1.
3. hidden bit set: pass in_e and in_m through unchanged.
4. lzc < in_e: out_m = in_m << lzc, out_e = in_e - lzc.
5. Otherwise (underflow), out_unf = 1:
   - With FP_NORM_DENORM_EN defined: shift left by (in_e == 0 ? 0 : in_e - 1) and set out_e = 0. This gives a gradual denormal.
   - Without it: flush to zero, out_e = 0, out_m = 0, out_zero = 1.

Exponent arithmetic:
- Done in EXP_W+1 bits so no wrap-around is possible.
- Exactly one of {out_zero, out_ovf} may be set, except that a flushed underflow sets both out_zero and out_unf.

Handshake:
- A beat transfers when valid && ready on the same edge.
- Each stage advances when its downstream slot is empty or is being drained this cycle:
  - s2_en = !s2_valid || out_ready
  - s1_en = !s1_valid || s2_en
  - in_ready = s1_en, which is purely registered and combinational from out_ready (no dependency on in_valid).
- A stalled stage holds its data and flags stable.
- out_e, out_m and the flags must not change while out_valid && !out_ready.
- Beats are never dropped or reordered.
- Simultaneous accept and drain in the same cycle is allowed and sustains 1 beat per cycle.

## Timing
- Latency: 2 cycles from input transfer to out_valid with out_ready held high.
- Throughput: 1 beat per clock.
- Reset:
  - Asynchronous assertion clears s1_valid, s2_valid, out_valid, out_e, out_m, out_zero, out_ovf and out_unf to 0.
  - in_ready is 1 once rst_n is low.
  - Reset mid-operation discards all in-flight beats. No partial beat appears after release.
- Release is synchronised externally. The first beat may be accepted on the first rising edge with rst_n high.
- With out_ready low and a continuous input stream, in_ready falls after 2 beats are accepted.

## Configuration
- FP_NORM_DENORM_EN defined: underflow produces a denormal (shift limited so out_e = 0), out_zero = 0 unless the shifted mantissa is 0, out_unf = 1.
- Not defined: underflow flushes to zero: out_e = 0, out_m = 0, out_zero = 1, out_unf = 1.

## Test plan
All scenarios use EXP_W=8, MAN_W=25.
- Left shift: in_e=0x80, in_m=0x0000010 -> out_e=0x6D, out_m=0x0800000, all flags 0, out_valid 2 cycles after transfer.
- Carry with sticky: in_e=0x7F, in_m=0x1800001 -> out_e=0x80, out_m=0x0C00001. Overflow: in_e=0xFE, in_m=0x1000000 -> out_e=0xFF, out_m=0, out_ovf=1.
- Zero and pass-through:
  - in_m=0 -> out_e=0, out_m=0, out_zero=1.
  - in_e=0x40, in_m=0x0800003 -> unchanged, flags 0.
- Underflow: in_e=0x03, in_m=0x0000100 -> with FP_NORM_DENORM_EN: out_e=0, out_m=0x0000400, out_unf=1. Without: out_e=0, out_m=0, out_zero=1, out_unf=1.
- Backpressure: stream 6 distinct beats with out_ready low for cycles 3-6 -> in_ready low after 2 accepted, outputs stable while stalled, all 6 emerge in order, none duplicated.
- Reset mid-stream: assert rst_n low with 2 beats in flight -> out_valid drops immediately, outputs 0, no stale beat after release.
